signnarrow_pack_8to2: RTL and testbench

- Narrows a stream of 8-bit signed values to 2-bit signed immediate fields. This is the inverse direction of the 2-to-8 sign extender.
- Checks each value for range and either saturates or truncates it.
- Packs FIELDS narrowed fields into one 8-bit word, with a valid/ready handshake on both sides.
- Sits in the assembler/loader path: produces packed 2-bit immediates from 8-bit datapath values.

---
 rtl/signnarrow_pack_8to2.sv | 91 +++++++++
 tb/tb_signnarrow_pack_8to2.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/signnarrow_pack_8to2.sv
// Narrows 8-bit signed values to 2-bit signed fields (saturating or truncating)
// and packs FIELDS of them per output word behind valid/ready handshakes.
module signnarrow_pack_8to2 #(
  parameter int SAT    = 1,
  parameter int FIELDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                flush,
  input  logic                ovf_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*FIELDS-1:0] out_data,
  output logic [2:0]          out_count,
  output logic [FIELDS-1:0]   out_ovf_mask,
  output logic                ovf_sticky
);

  logic [2*FIELDS-1:0] acc, acc_ins;
  logic [FIELDS-1:0]   acc_mask, mask_ins;
  logic [1:0]          cnt;
  logic [2:0]          cnt_ins;
  logic                flush_pend;
  logic [1:0]          field;
  logic                oor;
  logic                accept, can_load, word_done, flush_load, flush_clr, load;

  assign can_load = !out_valid || out_ready;
  assign in_ready = !flush_pend && (cnt != 2'(FIELDS - 1) || can_load);
  assign accept   = in_valid && in_ready;

  always_comb begin
    oor      = !((&in_data[7:1]) || !(|in_data[7:1]));
    field    = in_data[1:0];
    if (oor && SAT != 0)
      field = in_data[7] ? 2'b10 : 2'b01;
    acc_ins  = acc;
    mask_ins = acc_mask;
    cnt_ins  = {1'b0, cnt};
    if (accept) begin
      acc_ins[{cnt, 1'b0} +: 2] = field;
      mask_ins[cnt]             = oor;
      cnt_ins                   = cnt_ins + 3'd1;
    end
  end

  // The slot image including this cycle's accept is what either kind of load emits.
  assign word_done  = accept && cnt == 2'(FIELDS - 1);
  assign flush_load = flush_pend && can_load && cnt_ins != 3'd0;
  assign flush_clr  = flush_pend && (flush_load || cnt_ins == 3'd0);
  assign load       = word_done || flush_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc          <= '0;
      acc_mask     <= '0;
      cnt          <= '0;
      out_data     <= '0;
      out_count    <= '0;
      out_ovf_mask <= '0;
      out_valid    <= 1'b0;
      ovf_sticky   <= 1'b0;
      flush_pend   <= 1'b0;
    end else begin
      if (load) begin
        out_data     <= acc_ins;
        out_count    <= cnt_ins;
        out_ovf_mask <= mask_ins;
        out_valid    <= 1'b1;
        acc          <= '0;
        acc_mask     <= '0;
        cnt          <= '0;
      end else begin
        acc      <= acc_ins;
        acc_mask <= mask_ins;
        cnt      <= cnt_ins[1:0];
        if (out_ready)
          out_valid <= 1'b0;
      end
      flush_pend <= flush || (flush_pend && !flush_clr);
      if (accept && oor)
        ovf_sticky <= 1'b1;
      else if (ovf_clr)
        ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_signnarrow_pack_8to2.sv
// Scoreboard bench: directed vectors drive a saturating and a truncating
// instance in parallel; a monitor pops expected words on each output handshake.
module tb_signnarrow_pack_8to2;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, flush, ovf_clr, out_ready;
  logic [7:0] in_data;
  logic       r1, v1, s1, r0, v0, s0;
  logic [7:0] d1, d0;
  logic [2:0] c1, c0;
  logic [3:0] m1, m0;

  int nchk = 0;
  int nfail = 0;

  typedef struct {
    logic [7:0] dsat;
    logic [7:0] dtrunc;
    logic [2:0] cnt;
    logic [3:0] mask;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  signnarrow_pack_8to2 #(.SAT(1), .FIELDS(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
    .flush(flush), .ovf_clr(ovf_clr), .out_valid(v1), .out_ready(out_ready),
    .out_data(d1), .out_count(c1), .out_ovf_mask(m1), .ovf_sticky(s1)
  );

  signnarrow_pack_8to2 #(.SAT(0), .FIELDS(4)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
    .flush(flush), .ovf_clr(ovf_clr), .out_valid(v0), .out_ready(out_ready),
    .out_data(d0), .out_count(c0), .out_ovf_mask(m0), .ovf_sticky(s0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && v1 === 1'b1 && out_ready === 1'b1) begin
      chk("trunc_valid", 32'(v0), 32'd1);
      if (q.size() == 0) begin
        chk("unexpected_word", 32'(d1), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sat_data", 32'(d1), 32'(e.dsat));
        chk("sat_count", 32'(c1), 32'(e.cnt));
        chk("sat_mask", 32'(m1), 32'(e.mask));
        chk("trunc_data", 32'(d0), 32'(e.dtrunc));
        chk("trunc_mask", 32'(m0), 32'(e.mask));
      end
    end
  end

  // Drive one value and hold it until accepted (bounded); returns #1 after the accept edge.
  task automatic send(input logic [7:0] v, input bit want_ready);
    int unsigned n = 0;
    bit ok;
    in_valid = 1'b1;
    in_data  = v;
    do begin
      @(negedge clk);
      ok = r1;
      if (want_ready) chk("in_ready_high", 32'(r1), 32'd1);
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 32'(n), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] ds, input logic [7:0] dt, input logic [2:0] c,
                      input logic [3:0] m);
    exp_t e;
    e.dsat = ds; e.dtrunc = dt; e.cnt = c; e.mask = m;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 32'(v1), 32'd0);
    chk("rst_in_ready", 32'(r1), 32'd1);
    chk("rst_sticky", 32'(s1), 32'd0);
    chk("rst_out_data", 32'(d1), 32'd0);
    chk("rst_out_count", 32'(c1), 32'd0);

    // In-range word, full throughput, 1-cycle latency
    push(8'h8D, 8'h8D, 3'd4, 4'b0000);
    send(8'h01, 1); send(8'hFF, 1); send(8'h00, 1); send(8'hFE, 1);
    chk("latency_valid", 32'(v1), 32'd1);
    chk("inrange_sticky", 32'(s1), 32'd0);
    @(posedge clk); #1;

    // Out-of-range word: saturate vs truncate
    push(8'h99, 8'h71, 3'd4, 4'b1111);
    send(8'h05, 0); send(8'h80, 0); send(8'h7F, 0); send(8'hFD, 0);
    chk("oor_sticky_sat", 32'(s1), 32'd1);
    chk("oor_sticky_trunc", 32'(s0), 32'd1);
    ovf_clr = 1'b1; @(posedge clk); #1 ovf_clr = 1'b0;
    chk("clr_sticky", 32'(s1), 32'd0);

    // Backpressure: second word's last value stalls while first is held
    out_ready = 1'b0;
    push(8'hB4, 8'hB4, 3'd4, 4'b0000);
    push(8'hE1, 8'hE1, 3'd4, 4'b0000);
    send(8'h00, 0); send(8'h01, 0); send(8'hFF, 0); send(8'hFE, 0);
    send(8'h01, 0); send(8'h00, 0); send(8'hFE, 0);
    in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(r1), 32'd0);
      chk("bp_hold_valid", 32'(v1), 32'd1);
      chk("bp_hold_data", 32'(d1), 32'hB4);
      chk("bp_hold_count", 32'(c1), 32'd4);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Flush partial word, then next value starts in field 0
    push(8'h0D, 8'h0D, 3'd2, 4'b0000);
    send(8'h01, 0); send(8'hFF, 0);
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
    push(8'h02, 8'h02, 3'd4, 4'b0000);
    send(8'hFE, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    @(posedge clk); #1;

    // Reset mid-word discards the partial
    send(8'h40, 0); send(8'h01, 0); send(8'h01, 0);
    chk("pre_rst_sticky", 32'(s1), 32'd1);
    rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1;
    chk("midrst_out_valid", 32'(v1), 32'd0);
    chk("midrst_in_ready", 32'(r1), 32'd1);
    chk("midrst_sticky", 32'(s1), 32'd0);
    push(8'hB4, 8'hB4, 3'd4, 4'b0000);
    send(8'h00, 0); send(8'h01, 0); send(8'hFF, 0); send(8'hFE, 0);
    @(posedge clk); #1;

    // Overflowing accept beats same-cycle ovf_clr
    ovf_clr = 1'b1;
    send(8'h40, 0);
    ovf_clr = 1'b0;
    chk("clr_vs_ovf_sticky", 32'(s1), 32'd1);
    ovf_clr = 1'b1; @(posedge clk); #1 ovf_clr = 1'b0;
    chk("clr_alone_sticky", 32'(s1), 32'd0);
    push(8'h01, 8'h00, 3'd1, 4'b0001);
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
